// File: rtl/pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg_skid
// Purpose : Inter-stage pipeline register with a 2-entry skid buffer and a
//           synchronous flush. in_ready comes from registered state only.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_reg_skid #(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] CLR_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             clr,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   // Occupancy codes as {skid_v, main_v}; 2'b10 cannot be reached legally.
   localparam logic [1:0] c_empty = 2'b00;
   localparam logic [1:0] c_one   = 2'b01;
   localparam logic [1:0] c_full  = 2'b11;

   logic [WIDTH-1:0] r_main_q;
   logic [WIDTH-1:0] r_skid_q;
   logic             r_main_v;
   logic             r_skid_v;

   logic             w_in_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [1:0]       w_occ;

   assign w_in_ready = clr & ~r_skid_v;
   assign w_in_fire  = in_valid & w_in_ready;
   assign w_out_fire = r_main_v & out_ready;
   assign w_occ      = {r_skid_v, r_main_v};

   assign in_ready   = w_in_ready;
   assign out_valid  = r_main_v;
   assign out_data   = r_main_q;
   assign count      = {1'b0, r_main_v} + {1'b0, r_skid_v};

   always_ff @(posedge clock) begin
      if (!clr) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main_q <= CLR_VALUE;
         r_skid_q <= CLR_VALUE;
      end else if (flush) begin
         // Squash only the valid bits; payload registers keep their contents.
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else begin
         case (w_occ)
            c_empty: begin
               if (w_in_fire) begin
                  r_main_q <= in_data;
                  r_main_v <= 1'b1;
               end
            end
            c_one: begin
               if (w_in_fire && w_out_fire) begin
                  r_main_q <= in_data;
               end else if (w_in_fire) begin
                  r_skid_q <= in_data;
                  r_skid_v <= 1'b1;
               end else if (w_out_fire) begin
                  r_main_v <= 1'b0;
               end
            end
            c_full: begin
               if (w_out_fire) begin
                  r_main_q <= r_skid_q;
                  r_skid_v <= 1'b0;
               end
            end
            default: begin
               // Unreachable encoding: fall back to empty rather than lock up.
               r_main_v <= 1'b0;
               r_skid_v <= 1'b0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   a_skid_implies_main : assert property (@(posedge clock) disable iff (!clr)
      r_skid_v |-> r_main_v);

   a_no_fire_when_full : assert property (@(posedge clock) disable iff (!clr)
      !(w_in_fire && r_skid_v));

   a_stall_stable : assert property (@(posedge clock) disable iff (!clr)
      (r_main_v && !out_ready && !flush) |=> (r_main_v && $stable(r_main_q)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_reg_skid
// Purpose : Directed and random stimulus checked against a queue model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_reg_skid;

   logic        clock;
   logic        clr;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [1:0]  count;

   int total;
   int bad;
   bit run;

   logic [63:0] q[$];
   bit          stall_prev;
   logic [63:0] prev_data;

   pipe_reg_skid #(.WIDTH(64), .CLR_VALUE(64'h0)) dut (
      .clock     (clock),
      .clr       (clr),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input logic c, input logic f, input logic v,
                        input logic [63:0] d, input logic r);
      clr = c; flush = f; in_valid = v; in_data = d; out_ready = r;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Model: a FIFO of capacity two, cleared by reset or flush.
   always @(posedge clock) begin
      bit inf;
      stall_prev = clr && !flush && (q.size() > 0) && !out_ready;
      if (q.size() > 0) prev_data = q[0];
      if (!clr || flush) begin
         q.delete();
      end else begin
         inf = in_valid && (q.size() < 2);
         if ((q.size() > 0) && out_ready) void'(q.pop_front());
         if (inf) q.push_back(in_data);
      end
   end

   always @(negedge clock) begin
      int n;
      if (run) begin
         n = q.size();
         chk("m_in_ready",  {63'd0, in_ready},  {63'd0, (clr && n < 2)});
         chk("m_out_valid", {63'd0, out_valid}, {63'd0, (n > 0)});
         chk("m_count",     {62'd0, count},     64'(n));
         if (n > 0) chk("m_out_data", out_data, q[0]);
         if (stall_prev) chk("m_stall_hold", out_data, prev_data);
      end
   end

   initial begin
      total = 0; bad = 0; run = 1'b1;
      stall_prev = 1'b0; prev_data = '0;

      // Reset with traffic presented.
      drive(0, 0, 1, 64'hDEAD, 0);
      step(); step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_count",     {62'd0, count},     64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
      chk("rst_out_data",  out_data,           64'd0);
      drive(1, 0, 0, 64'h0, 0);
      #1;
      chk("rel_in_ready",  {63'd0, in_ready},  64'd1);

      // Streaming 0x1..0x10.
      for (int i = 1; i <= 16; i++) begin
         drive(1, 0, 1, 64'(i), 1);
         step();
         chk("str_out_valid", {63'd0, out_valid}, 64'd1);
         chk("str_out_data",  out_data,           64'(i));
         chk("str_count",     {62'd0, count},     64'd1);
         chk("str_in_ready",  {63'd0, in_ready},  64'd1);
      end
      drive(1, 0, 0, 64'h0, 1);
      step();
      chk("str_drain", {62'd0, count}, 64'd0);

      // Stall and skid.
      drive(1, 0, 1, 64'hA, 0); step();
      chk("sk_a", out_data, 64'hA);
      drive(1, 0, 1, 64'hB, 0); step();
      chk("sk_count2", {62'd0, count},    64'd2);
      chk("sk_ready0", {63'd0, in_ready}, 64'd0);
      chk("sk_hold_a", out_data,          64'hA);
      drive(1, 0, 1, 64'hC, 0); step();
      chk("sk_c_held", {62'd0, count},    64'd2);
      chk("sk_still_a", out_data,         64'hA);
      drive(1, 0, 1, 64'hC, 1); #1;
      chk("sk_out_a", out_data, 64'hA);
      step();
      chk("sk_out_b",   out_data,          64'hB);
      chk("sk_count1",  {62'd0, count},    64'd1);
      chk("sk_ready1",  {63'd0, in_ready}, 64'd1);
      step();
      chk("sk_out_c",   out_data,          64'hC);
      drive(1, 0, 0, 64'h0, 1); step();
      chk("sk_empty",   {62'd0, count},    64'd0);

      // Flush while full.
      drive(1, 0, 1, 64'hA, 0); step();
      drive(1, 0, 1, 64'hB, 0); step();
      chk("fl_full", {62'd0, count}, 64'd2);
      drive(1, 1, 1, 64'hF, 0); step();
      chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_count",     {62'd0, count},     64'd0);
      chk("fl_in_ready",  {63'd0, in_ready},  64'd1);
      drive(1, 0, 0, 64'h0, 1); step();
      chk("fl_no_f", {63'd0, out_valid}, 64'd0);

      // Reset mid-operation.
      drive(1, 0, 1, 64'hA, 0); step();
      drive(1, 0, 1, 64'hB, 0); step();
      drive(0, 0, 0, 64'h0, 1); step();
      chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
      chk("mr_out_data",  out_data,           64'd0);
      chk("mr_count",     {62'd0, count},     64'd0);
      drive(1, 0, 1, 64'h55, 1); step();
      chk("mr_first_valid", {63'd0, out_valid}, 64'd1);
      chk("mr_first_data",  out_data,           64'h55);
      drive(1, 0, 0, 64'h0, 1); step();
      chk("mr_empty", {62'd0, count}, 64'd0);

      // Random traffic; the negedge comparator does the checking.
      for (int k = 0; k < 10000; k++) begin
         drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), {$urandom, $urandom},
               ($urandom_range(0, 3) != 0));
         step();
      end

      drive(1, 0, 0, 64'h0, 1);
      step(); step();
      run = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised pipeline register for inter-stage latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds WIDTH bits of stage payload behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput, and in_ready is driven from registered state only, so there is no combinational path from out_ready.
- A synchronous flush squashes in-flight contents on branch mispredict or exception.

Parameters:
WIDTH, 64, payload width in bits (minimum 1).
CLR_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
clr  input  1  synchronous, active-low reset; sampled on the rising clock edge.
flush  input  1  synchronous squash; active-high.
in_valid  input  1  upstream payload valid.
in_ready  output  1  block can accept a payload this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  out_data holds a valid payload.
out_ready  input  1  downstream accepts this cycle; low means stall.
out_data  output  WIDTH  payload; always driven from main_q.
count  output  2  occupancy, 0 to 2.

Behaviour:
- Storage:
  - main_q / main_v: output entry.
  - skid_q / skid_v: overflow entry.
  - State is encoded by occupancy: EMPTY (0), ONE (1), FULL (2).
- Handshake signals:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = clr & ~skid_v. It depends only on clr and registered state.
  - out_valid = main_v.
  - count = main_v + skid_v.
- Reset: when clr is low at an edge:
  - main_v and skid_v go to 0.
  - main_q and skid_q go to CLR_VALUE.
  - in_ready is low while clr is low, so nothing is accepted during reset.
- Priority at each edge: clr, then flush, then normal transitions.
- Flush: when flush is high at an edge and clr is high:
  - main_v and skid_v go to 0; data registers hold their values.
  - A payload presented with in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as consumed downstream.
  - Next cycle: count = 0, in_ready = 1.
- Normal transitions:
  - EMPTY + in_fire: main_q <= in_data; go to ONE.
  - EMPTY, no in_fire: stay.
  - ONE + in_fire + out_fire: main_q <= in_data; stay ONE (streaming, 1 payload per cycle).
  - ONE + in_fire only: skid_q <= in_data; go to FULL.
  - ONE + out_fire only: go to EMPTY.
  - FULL: in_ready = 0.
  - FULL + out_fire: main_q <= skid_q; go to ONE.
  - FULL, no out_fire: hold.
- Latency: payload accepted at edge N is on out_data with out_valid in cycle N+1 when the block was EMPTY, or when ONE with out_fire in the same cycle.
- Ordering: strict FIFO; no payload is dropped or duplicated outside flush/reset.
- Stability: while out_valid & ~out_ready, out_data and out_valid hold, and main_q is not written.
- Data registers are written only when the corresponding entry is loaded; there is no enable-less write.
- Width rules:
  - No arithmetic on the payload.
  - count never exceeds 2; reaching 3 is illegal.
- Assertions:
  - skid_v implies main_v.
  - No in_fire while skid_v.
  - out_data stable under stall.

Test Plan:
- Reset: clr=0 for 2 cycles with in_valid=1, in_data=64'hDEAD → out_valid=0, count=0, in_ready=0, out_data=0; first cycle after clr=1: in_ready=1.
- Streaming: out_ready=1; feed 0x1,0x2,…,0x10 on consecutive cycles → out_data 0x1..0x10 on consecutive cycles, each one cycle after acceptance; count stays 1; in_ready never drops.
- Stall/skid: accept 0xA; hold out_ready=0 and present 0xB then 0xC → 0xB is taken into skid, count=2, in_ready=0, 0xC is held upstream. Raise out_ready → out 0xA, then 0xB, then 0xC; no loss or duplication.
- Flush while FULL: state holds 0xA/0xB; assert flush with in_valid=1, in_data=0xF → next cycle out_valid=0, count=0, in_ready=1; 0xF never appears on the output.
- Reset mid-operation: FULL with out_ready=1; drop clr for one cycle → out_valid=0 and out_data=CLR_VALUE next cycle; the remaining entry is lost; the first payload after release passes with 1-cycle latency.
- Random: random in_valid/out_ready with 10% flush over 10k cycles against a scoreboard → order preserved, out_data stable under stall, assertions never fire.
